imem_boot_sequencer: RTL and testbench

Boot and run controller for the 5-stage RISC-V core. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them byte-wise, big-endian, into the core's instruction memory byte port. It then holds the core in reset for a fixed number of cycles, releases it for a programmed cycle budget, and reports completion. It replaces hierarchical preloading of instruction memory and sits between the bench/host and the `Core` top level.

---
 rtl/imem_boot_sequencer_pkg.sv | 24 ++
 rtl/imem_boot_sequencer_if.sv | 22 ++
 rtl/imem_boot_sequencer_down_counter.sv | 26 ++
 rtl/imem_boot_sequencer.sv | 155 +++++++++++++++
 tb/tb_imem_boot_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_boot_sequencer_pkg.sv
// Shared types and helpers for the instruction-memory boot sequencer.
// Provides the controller state enum and the big-endian byte-lane selector.
package boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_HOLD,
    S_RUN,
    S_DONE
  } boot_state_e;

  // Lane 0 is the most significant byte: memory is big-endian.
  function automatic logic [7:0] byte_lane(
    input logic [31:0] word,
    input logic [1:0]  k
  );
    logic [31:0] s;
    s = word >> (5'd24 - {k, 3'b000});
    return s[7:0];
  endfunction

endpackage

// File: rtl/imem_boot_sequencer_if.sv
// Word-stream load handshake into the boot sequencer.
// Signals: load_valid, load_ready, load_data[31:0], load_last.
interface imem_boot_sequencer_if;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );
endinterface

// File: rtl/imem_boot_sequencer_down_counter.sv
// Loadable saturating down counter shared by the HOLD and RUN phases.
// Ports: clock, reset, load, value, dec in; zero out (count == 0).
module boot_down_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && !zero) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);
endmodule

// File: rtl/imem_boot_sequencer.sv
// Loads a word stream byte-wise into instruction memory, then resets and runs the core.
// Ports: clock, reset, start, run_cycles, load (slave), imem_*, core_reset, mem_en, busy, done, error.
module imem_boot_sequencer
  import boot_pkg::*;
#(
  parameter int IMEM_BYTES = 1024,
  parameter int ADDR_W     = $clog2(IMEM_BYTES),
  parameter int RESET_HOLD = 3,
  parameter int RUN_W      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [RUN_W-1:0]     run_cycles,
  imem_boot_sequencer_if.slave load,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [7:0]           imem_wdata,
  output logic                 core_reset,
  output logic                 mem_en,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);
  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] IDX_MAX =
    IDX_W'(IMEM_BYTES / 4 - 1);
  localparam logic [RUN_W-1:0] HOLD_INIT =
    RUN_W'(RESET_HOLD - 1);

  boot_state_e      state;
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [1:0]       lane_nx;
  logic [31:0]      word;
  logic             last;
  logic [RUN_W-1:0] budget;

  logic             cnt_load;
  logic             cnt_dec;
  logic [RUN_W-1:0] cnt_value;
  logic             cnt_zero;

  assign lane_nx = lane + 2'd1;

  // Counter is preloaded with N-1 on phase entry so the phase
  // lasts exactly N cycles; zero marks the final cycle.
  assign cnt_load =
    (state == S_WRITE && lane == 2'd3 && last) ||
    (state == S_HOLD && cnt_zero);
  assign cnt_value =
    (state == S_HOLD) ? budget - 1'b1 : HOLD_INIT;
  assign cnt_dec =
    (state == S_HOLD) || (state == S_RUN);

  boot_down_counter #(
    .W(RUN_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .load  (cnt_load),
    .value (cnt_value),
    .dec   (cnt_dec),
    .zero  (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      idx             <= '0;
      lane            <= '0;
      word            <= '0;
      last            <= 1'b0;
      budget          <= '0;
      load.load_ready <= 1'b0;
      imem_we         <= 1'b0;
      imem_addr       <= '0;
      imem_wdata      <= '0;
      core_reset      <= 1'b1;
      mem_en          <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state           <= S_LOAD;
            idx             <= '0;
            budget          <= run_cycles;
            done            <= 1'b0;
            error           <= 1'b0;
            busy            <= 1'b1;
            load.load_ready <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load.load_valid) begin
            state           <= S_WRITE;
            word            <= load.load_data;
            last            <= load.load_last;
            lane            <= 2'd0;
            load.load_ready <= 1'b0;
            imem_we         <= 1'b1;
            imem_addr       <= {idx, 2'd0};
            imem_wdata      <=
              byte_lane(load.load_data, 2'd0);
          end
        end
        S_WRITE: begin
          if (lane == 2'd3) begin
            imem_we <= 1'b0;
            idx     <= idx + 1'b1;
            if (last) begin
              state <= S_HOLD;
            end else if (idx == IDX_MAX) begin
              // Next word would wrap the index.
              state <= S_DONE;
              done  <= 1'b1;
              error <= 1'b1;
              busy  <= 1'b0;
            end else begin
              state           <= S_LOAD;
              load.load_ready <= 1'b1;
            end
          end else begin
            lane       <= lane_nx;
            imem_addr  <= {idx, lane_nx};
            imem_wdata <= byte_lane(word, lane_nx);
          end
        end
        S_HOLD: begin
          if (cnt_zero) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
            mem_en     <= 1'b1;
          end
        end
        S_RUN: begin
          // A zero budget never terminates.
          if (cnt_zero && budget != '0) begin
            state      <= S_DONE;
            core_reset <= 1'b1;
            mem_en     <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_imem_boot_sequencer.sv
// Scoreboard bench for imem_boot_sequencer with randomized word streams.
// Byte writes are checked against a word-level model; phase timing from recorded edges.
module tb_imem_boot_sequencer;
  localparam int IMEM_BYTES = 64;
  localparam int ADDR_W     = 6;
  localparam int RESET_HOLD = 3;
  localparam int RUN_W      = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [RUN_W-1:0]  run_cycles = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic              core_reset;
  logic              mem_en;
  logic              busy;
  logic              done;
  logic              error;

  imem_boot_sequencer_if load_if ();

  imem_boot_sequencer #(
    .IMEM_BYTES (IMEM_BYTES),
    .ADDR_W     (ADDR_W),
    .RESET_HOLD (RESET_HOLD),
    .RUN_W      (RUN_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .run_cycles (run_cycles),
    .load       (load_if),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .mem_en     (mem_en),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [7:0]        d;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] prog[$];
  logic [7:0]  mem[IMEM_BYTES];
  int checks = 0;
  int errors = 0;
  int widx   = 0;
  int wr_cnt = 0;
  int cyc    = 0;
  int last_wr = -1;
  int fall   = -1;
  int rise   = -1;
  int done_c = -1;

  initial forever #5 clock = ~clock;
  initial forever begin
    @(posedge clock);
    cyc++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every byte write and records
  // the cycle of each core_reset / done edge.
  initial begin
    logic prev_cr;
    logic prev_dn;
    exp_t e;
    prev_cr = 1'b1;
    prev_dn = 1'b0;
    forever begin
      @(negedge clock);
      if (imem_we === 1'b1) begin
        mem[imem_addr] = imem_wdata;
        wr_cnt++;
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=%h:%h required=none",
                   imem_addr, imem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("byte_addr", 32'(imem_addr), 32'(e.a));
          chk("byte_data", 32'(imem_wdata), 32'(e.d));
        end
      end
      chk("mem_en_vs_core_reset", 32'(mem_en), 32'(!core_reset));
      if (prev_cr && !core_reset) fall = cyc;
      if (!prev_cr && core_reset) rise = cyc;
      if (!prev_dn && done) done_c = cyc;
      prev_cr = core_reset;
      prev_dn = done;
    end
  end

  // Word-level model: word i occupies bytes 4i..4i+3, MSB first.
  task automatic model_word(input logic [31:0] w);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.a = ADDR_W'(4 * widx + k);
      e.d = 8'(w >> (24 - 8 * k));
      exp_q.push_back(e);
    end
    widx++;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push_word(input logic [31:0] w, input bit lst,
                           input bit toggle, input int limit,
                           output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    load_if.load_data = w;
    load_if.load_last = lst;
    while (n < limit) begin
      load_if.load_valid =
        toggle ? 1'($urandom_range(0, 1)) : 1'b1;
      if (load_if.load_valid && load_if.load_ready) begin
        ok = 1'b1;
        break;
      end
      n++;
      @(negedge clock);
    end
    if (ok) model_word(w);
    @(negedge clock);
    load_if.load_valid = 1'b0;
  endtask

  task automatic begin_session(input int rc);
    widx = 0;
    wr_cnt = 0;
    fall = -1;
    rise = -1;
    done_c = -1;
    @(negedge clock);
    start = 1'b1;
    run_cycles = RUN_W'(rc);
    @(negedge clock);
    start = 1'b0;
    chk("start_ready", 32'(load_if.load_ready), 32'd1);
    chk("start_done_clr", 32'(done), 32'd0);
    chk("start_err_clr", 32'(error), 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic session(input int rc, input bit toggle,
                         input bit poke_run);
    bit ok;
    int t;
    int nw;
    nw = prog.size();
    begin_session(rc);
    for (int i = 0; i < nw; i++) begin
      push_word(prog[i], i == nw - 1, toggle, 100, ok);
      chk("accept", 32'(ok), 32'd1);
    end
    if (poke_run) begin
      t = 0;
      while (core_reset && t < 200) begin
        @(negedge clock);
        t++;
      end
      chk("reach_run", 32'(core_reset), 32'd0);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      chk("run_start_ignored", 32'(load_if.load_ready), 32'd0);
    end
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    chk("done_seen", 32'(done), 32'd1);
    chk("write_count", 32'(wr_cnt), 32'(4 * nw));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("hold_len", 32'(fall - last_wr), 32'(RESET_HOLD + 1));
    chk("run_len", 32'(rise - fall), 32'(rc));
    chk("done_after_run", 32'(done_c), 32'(rise));
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_error", 32'(error), 32'd0);
    chk("end_core_reset", 32'(core_reset), 32'd1);
  endtask

  task automatic rand_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  initial begin
    bit ok;
    int t;
    load_if.load_valid = 1'b0;
    load_if.load_data  = '0;
    load_if.load_last  = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_ready", 32'(load_if.load_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    reset = 1'b0;

    // Fixed program, budget 10.
    prog.delete();
    prog.push_back(32'h0000_0000);
    prog.push_back(32'h0502_8293);
    prog.push_back(32'h0142_8213);
    prog.push_back(32'h0042_8533);
    prog.push_back(32'h4042_8633);
    session(10, 1'b0, 1'b0);
    chk("mem4", 32'(mem[4]), 32'h05);
    chk("mem5", 32'(mem[5]), 32'h02);
    chk("mem6", 32'(mem[6]), 32'h82);
    chk("mem7", 32'(mem[7]), 32'h93);
    chk("mem16", 32'(mem[16]), 32'h40);
    chk("mem17", 32'(mem[17]), 32'h42);
    chk("mem18", 32'(mem[18]), 32'h86);
    chk("mem19", 32'(mem[19]), 32'h33);

    // Random streams, toggling valid, start pokes during RUN.
    for (int s = 0; s < 3; s++) begin
      rand_prog($urandom_range(1, 8));
      session($urandom_range(3, 20), 1'b1, 1'b1);
    end
    rand_prog($urandom_range(1, 8));
    session($urandom_range(1, 20), 1'b0, 1'b0);

    // Reset during the third byte of a word.
    begin_session(5);
    push_word($urandom, 1'b0, 1'b0, 100, ok);
    chk("mid_accept", 32'(ok), 32'd1);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_we", 32'(imem_we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(load_if.load_ready), 32'd0);
    chk("mid_rst_core", 32'(core_reset), 32'd1);
    exp_q.delete();
    reset = 1'b0;
    rand_prog(2);
    session(5, 1'b0, 1'b0);

    // Overflow: fill memory without last, then one more word.
    begin_session(5);
    for (int i = 0; i < IMEM_BYTES / 4; i++) begin
      push_word($urandom, 1'b0, 1'b0, 100, ok);
      chk("ovf_accept", 32'(ok), 32'd1);
    end
    push_word($urandom, 1'b0, 1'b0, 30, ok);
    chk("ovf_extra_refused", 32'(ok), 32'd0);
    chk("ovf_error", 32'(error), 32'd1);
    chk("ovf_done", 32'(done), 32'd1);
    chk("ovf_busy", 32'(busy), 32'd0);
    chk("ovf_writes", 32'(wr_cnt), 32'(IMEM_BYTES));
    chk("ovf_queue", 32'(exp_q.size()), 32'd0);
    chk("ovf_no_run", 32'(fall), 32'hFFFF_FFFF);

    // Zero budget: runs until reset.
    rand_prog(2);
    begin_session(0);
    for (int i = 0; i < 2; i++) begin
      push_word(prog[i], i == 1, 1'b0, 100, ok);
      chk("inf_accept", 32'(ok), 32'd1);
    end
    t = 0;
    while (core_reset && t < 200) begin
      @(negedge clock);
      t++;
    end
    repeat (300) @(negedge clock);
    chk("inf_core_reset", 32'(core_reset), 32'd0);
    chk("inf_mem_en", 32'(mem_en), 32'd1);
    chk("inf_done", 32'(done), 32'd0);
    chk("inf_busy", 32'(busy), 32'd1);
    chk("inf_hold_len", 32'(fall - last_wr), 32'(RESET_HOLD + 1));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("inf_rst_core", 32'(core_reset), 32'd1);
    chk("inf_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
